// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types, constants and BCD helper for the scoreboard formatter
package scoreboard_pkg;

    localparam int MIN_STEPS   = 4;
    localparam int SEC_PER_MIN = 60;
    localparam int CONV_BITS   = 8;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_MIN,
        ST_CONV_SEC,
        ST_CONV_BLUE,
        ST_CONV_RED,
        ST_COMMIT
    } state_t;

    // One double-dabble step on {hundreds, tens, ones, binary}: add 3 to any
    // digit >= 5, then shift the whole register left by one.
    function automatic logic [19:0] dabble_step(input logic [19:0] sr);
        logic [19:0] adj;
        adj = sr;
        for (int d = 0; d < 3; d++) begin
            if (adj[8 + 4*d +: 4] >= 4'd5) begin
                adj[8 + 4*d +: 4] = adj[8 + 4*d +: 4] + 4'd3;
            end
        end
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/scoreboard_formatter_if.sv
// rtl/scoreboard_formatter_if.sv - raw game values in, registered BCD display fields out
interface scoreboard_formatter_if;
    import scoreboard_pkg::*;

    logic [7:0]  time_left;
    logic [6:0]  blue_score;
    logic [6:0]  red_score;
    logic        game_over;

    bcd_digit_t  time_min;
    logic [7:0]  time_sec;
    logic [11:0] blue_bcd;
    logic [11:0] red_bcd;
    logic        update;
    logic        busy;
    logic        display_on;

    // Game controller side: drives raw values, consumes digits.
    modport master (
        output time_left, blue_score, red_score, game_over,
        input  time_min, time_sec, blue_bcd, red_bcd, update, busy, display_on
    );

    // Formatter side.
    modport slave (
        input  time_left, blue_score, red_score, game_over,
        output time_min, time_sec, blue_bcd, red_bcd, update, busy, display_on
    );

endinterface

// File: rtl/scoreboard_formatter_bin2bcd_serial.sv
// rtl/scoreboard_formatter_bin2bcd_serial.sv - 8-bit serial double-dabble converter, fixed 9-cycle latency
module bin2bcd_serial
    import scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    logic [19:0] sr_q;
    logic [3:0]  step_q;
    logic        run_q;
    logic        done_q;

    // Load on start, run CONV_BITS shift-add-3 steps, then flag done for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (run_q) begin
                sr_q   <= dabble_step(sr_q);
                step_q <= step_q + 4'd1;
                if (step_q == 4'(CONV_BITS - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start) begin
                sr_q   <= {12'd0, bin};
                step_q <= '0;
                run_q  <= 1'b1;
            end
        end
    end

    // The result stays in the upper digits until the next start reloads.
    assign bcd  = sr_q[19:8];
    assign done = done_q;

endmodule

// File: rtl/scoreboard_formatter.sv
// rtl/scoreboard_formatter.sv - converts game time and scores to atomically committed BCD fields plus blink gate
module scoreboard_formatter
    import scoreboard_pkg::*;
#(
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    scoreboard_formatter_if.slave sb
);

    localparam int BLINK_W = $clog2(BLINK_CYCLES);

    state_t      state_q, state_d;

    logic [7:0]  snap_time_q;
    logic [6:0]  snap_blue_q;
    logic [6:0]  snap_red_q;
    logic        primed_q;

    logic [7:0]  rem_q;
    logic [2:0]  min_q;
    logic [1:0]  step_q;
    logic        started_q;

    logic [7:0]  stage_sec_q;
    logic [11:0] stage_blue_q;
    logic [11:0] stage_red_q;

    bcd_digit_t  time_min_q;
    logic [7:0]  time_sec_q;
    logic [11:0] blue_bcd_q;
    logic [11:0] red_bcd_q;
    logic        update_q;
    logic        busy_q;

    logic [BLINK_W-1:0] blink_cnt_q;
    logic        display_on_q;

    logic        cvt_start;
    logic [7:0]  cvt_bin;
    logic [11:0] cvt_bcd;
    logic        cvt_done;

    bin2bcd_serial u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (cvt_start),
        .bin   (cvt_bin),
        .bcd   (cvt_bcd),
        .done  (cvt_done)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and converter request; start is issued once on entry to each CONV state.
    always_comb begin
        state_d   = state_q;
        cvt_start = 1'b0;
        cvt_bin   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (!primed_q
                    || (sb.time_left  != snap_time_q)
                    || (sb.blue_score != snap_blue_q)
                    || (sb.red_score  != snap_red_q)) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: state_d = ST_MIN;
            ST_MIN: begin
                if (step_q == 2'(MIN_STEPS - 1)) begin
                    state_d = ST_CONV_SEC;
                end
            end
            ST_CONV_SEC: begin
                cvt_bin   = rem_q;
                cvt_start = !started_q;
                if (cvt_done) state_d = ST_CONV_BLUE;
            end
            ST_CONV_BLUE: begin
                cvt_bin   = {1'b0, snap_blue_q};
                cvt_start = !started_q;
                if (cvt_done) state_d = ST_CONV_RED;
            end
            ST_CONV_RED: begin
                cvt_bin   = {1'b0, snap_red_q};
                cvt_start = !started_q;
                if (cvt_done) state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pass datapath: snapshot, fixed-length minutes division, staging, atomic commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_time_q  <= '0;
            snap_blue_q  <= '0;
            snap_red_q   <= '0;
            primed_q     <= 1'b0;
            rem_q        <= '0;
            min_q        <= '0;
            step_q       <= '0;
            started_q    <= 1'b0;
            stage_sec_q  <= '0;
            stage_blue_q <= '0;
            stage_red_q  <= '0;
            time_min_q   <= '0;
            time_sec_q   <= '0;
            blue_bcd_q   <= '0;
            red_bcd_q    <= '0;
            update_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (cvt_start) started_q <= 1'b1;
            if (cvt_done)  started_q <= 1'b0;
            case (state_q)
                ST_SNAP: begin
                    snap_time_q <= sb.time_left;
                    snap_blue_q <= sb.blue_score;
                    snap_red_q  <= sb.red_score;
                    rem_q       <= sb.time_left;
                    min_q       <= '0;
                    step_q      <= '0;
                    primed_q    <= 1'b1;
                    busy_q      <= 1'b1;
                end
                ST_MIN: begin
                    if (rem_q >= 8'(SEC_PER_MIN)) begin
                        rem_q <= rem_q - 8'(SEC_PER_MIN);
                        min_q <= min_q + 3'd1;
                    end
                    step_q <= step_q + 2'd1;
                end
                ST_CONV_SEC:  if (cvt_done) stage_sec_q  <= cvt_bcd[7:0];
                ST_CONV_BLUE: if (cvt_done) stage_blue_q <= cvt_bcd;
                ST_CONV_RED:  if (cvt_done) stage_red_q  <= cvt_bcd;
                ST_COMMIT: begin
                    time_min_q <= {1'b0, min_q};
                    time_sec_q <= stage_sec_q;
                    blue_bcd_q <= stage_blue_q;
                    red_bcd_q  <= stage_red_q;
                    update_q   <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Game-over blink: free-running half-period counter, display forced on while not over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q  <= '0;
            display_on_q <= 1'b1;
        end else if (!sb.game_over) begin
            blink_cnt_q  <= '0;
            display_on_q <= 1'b1;
        end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_q  <= '0;
            display_on_q <= ~display_on_q;
        end else begin
            blink_cnt_q  <= blink_cnt_q + BLINK_W'(1);
        end
    end

    assign sb.time_min   = time_min_q;
    assign sb.time_sec   = time_sec_q;
    assign sb.blue_bcd   = blue_bcd_q;
    assign sb.red_bcd    = red_bcd_q;
    assign sb.update     = update_q;
    assign sb.busy       = busy_q;
    assign sb.display_on = display_on_q;

endmodule

// File: tb/tb_scoreboard_formatter.sv
// tb/tb_scoreboard_formatter.sv - self-checking bench for scoreboard_formatter
module tb_scoreboard_formatter;

    localparam int BLINK = 4;

    logic clk;
    logic rst;

    scoreboard_formatter_if sb_if();

    scoreboard_formatter #(.BLINK_CYCLES(BLINK)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          t;
        int          b;
        int          r;
        logic [3:0]  e_min;
        logic [7:0]  e_sec;
        logic [11:0] e_blue;
        logic [11:0] e_red;
    } vec_t;

    vec_t vecs[9];

    int vectors = 0;
    int miscompares = 0;
    int cur_t, cur_b, cur_r;

    function automatic logic [3:0] exp_min(input int t);
        return 4'(t / 60);
    endfunction

    function automatic logic [7:0] exp_sec(input int t);
        int s;
        s = t % 60;
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [11:0] exp_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic [3:0] e_min, input logic [7:0] e_sec,
                                input logic [11:0] e_blue, input logic [11:0] e_red);
        check({tag, "_time_min"}, 32'(sb_if.time_min), 32'(e_min));
        check({tag, "_time_sec"}, 32'(sb_if.time_sec), 32'(e_sec));
        check({tag, "_blue_bcd"}, 32'(sb_if.blue_bcd), 32'(e_blue));
        check({tag, "_red_bcd"},  32'(sb_if.red_bcd),  32'(e_red));
    endtask

    task automatic apply(input int t, input int b, input int r);
        cur_t = t;
        cur_b = b;
        cur_r = r;
        sb_if.time_left  = 8'(t);
        sb_if.blue_score = 7'(b);
        sb_if.red_score  = 7'(r);
    endtask

    task automatic wait_update(output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (sb_if.busy) busy_cycles++;
            if (sb_if.update) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_pass(input string tag, input int t, input int b, input int r,
                           input logic [3:0] e_min, input logic [7:0] e_sec,
                           input logic [11:0] e_blue, input logic [11:0] e_red);
        int lat, bc;
        apply(t, b, r);
        wait_update(lat, bc);
        check({tag, "_latency"}, lat, 37);
        check({tag, "_busy_cycles"}, bc, 35);
        check_fields(tag, e_min, e_sec, e_blue, e_red);
        @(negedge clk);
        check({tag, "_update_width"}, 32'(sb_if.update), 0);
    endtask

    task automatic mid_pass(input string tag, input int t0, input int b0, input int r0,
                            input int t1, input int b1, input int r1, input int at_k);
        int lat, bc;
        apply(t0, b0, r0);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == at_k) apply(t1, b1, r1);
            if (sb_if.update) begin
                lat = k;
                break;
            end
        end
        check({tag, "_first_latency"}, lat, 37);
        check_fields({tag, "_first"}, exp_min(t0), exp_sec(t0), exp_bcd(b0), exp_bcd(r0));
        wait_update(lat, bc);
        check({tag, "_second_spacing"}, lat, 37);
        check_fields({tag, "_second"}, exp_min(t1), exp_sec(t1), exp_bcd(b1), exp_bcd(r1));
        @(negedge clk);
        check({tag, "_update_width"}, 32'(sb_if.update), 0);
    endtask

    task automatic rand_inputs(output int t, output int b, output int r);
        t = int'($urandom_range(255, 0));
        b = int'($urandom_range(127, 0));
        r = int'($urandom_range(127, 0));
        if (t == cur_t && b == cur_b && r == cur_r) t = (t + 1) % 256;
    endtask

    initial begin
        int lat, bc, seen, seen_busy;
        int t, b, r, t1, b1, r1, k;

        vecs[0] = '{180,   0,  0, 4'd3, 8'h00, 12'h000, 12'h000};
        vecs[1] = '{255, 127, 99, 4'd4, 8'h15, 12'h127, 12'h099};
        vecs[2] = '{ 60,   5,  5, 4'd1, 8'h00, 12'h005, 12'h005};
        vecs[3] = '{ 59,   5,  5, 4'd0, 8'h59, 12'h005, 12'h005};
        vecs[4] = '{  0,   5,  5, 4'd0, 8'h00, 12'h005, 12'h005};
        vecs[5] = '{119,  64, 45, 4'd1, 8'h59, 12'h064, 12'h045};
        vecs[6] = '{240,  50,127, 4'd4, 8'h00, 12'h050, 12'h127};
        vecs[7] = '{ 61,  99,100, 4'd1, 8'h01, 12'h099, 12'h100};
        vecs[8] = '{121, 100,  1, 4'd2, 8'h01, 12'h100, 12'h001};

        rst = 1'b1;
        sb_if.game_over = 1'b0;
        apply(vecs[0].t, vecs[0].b, vecs[0].r);
        repeat (2) @(negedge clk);
        check_fields("reset", 4'd0, 8'h00, 12'h000, 12'h000);
        check("reset_update", 32'(sb_if.update), 0);
        check("reset_busy", 32'(sb_if.busy), 0);
        check("reset_display_on", 32'(sb_if.display_on), 1);

        rst = 1'b0;
        wait_update(lat, bc);
        check("vec0_latency", lat, 37);
        check("vec0_busy_cycles", bc, 35);
        check_fields("vec0", vecs[0].e_min, vecs[0].e_sec, vecs[0].e_blue, vecs[0].e_red);
        @(negedge clk);

        for (int i = 1; i < 9; i++) begin
            do_pass($sformatf("vec%0d", i), vecs[i].t, vecs[i].b, vecs[i].r,
                    vecs[i].e_min, vecs[i].e_sec, vecs[i].e_blue, vecs[i].e_red);
        end

        mid_pass("blue_step", 30, 5, 7, 30, 6, 7, 11);

        apply(200, 12, 34);
        for (int i = 1; i <= 21; i++) @(negedge clk);
        check("rst_mid_busy", 32'(sb_if.busy), 1);
        rst = 1'b1;
        #1;
        check_fields("rst_mid", 4'd0, 8'h00, 12'h000, 12'h000);
        check("rst_mid_update", 32'(sb_if.update), 0);
        check("rst_mid_busy_clear", 32'(sb_if.busy), 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (sb_if.update) seen++;
        end
        check("rst_mid_no_update", seen, 0);
        rst = 1'b0;
        wait_update(lat, bc);
        check("rst_release_latency", lat, 37);
        check_fields("rst_release", exp_min(200), exp_sec(200), exp_bcd(12), exp_bcd(34));
        @(negedge clk);

        seen = 0;
        seen_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (sb_if.update) seen++;
            if (sb_if.busy) seen_busy++;
        end
        check("idle_no_update", seen, 0);
        check("idle_no_busy", seen_busy, 0);

        check("blink_pre", 32'(sb_if.display_on), 1);
        sb_if.game_over = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            check($sformatf("blink_k%0d", j), 32'(sb_if.display_on), 32'(((j / BLINK) % 2) == 0));
        end
        sb_if.game_over = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            check($sformatf("blink_drop%0d", j), 32'(sb_if.display_on), 1);
        end

        for (int i = 0; i < 20; i++) begin
            rand_inputs(t, b, r);
            do_pass($sformatf("rand%0d", i), t, b, r, exp_min(t), exp_sec(t), exp_bcd(b), exp_bcd(r));
        end

        for (int i = 0; i < 4; i++) begin
            rand_inputs(t, b, r);
            t1 = (t + 1 + int'($urandom_range(254, 0))) % 256;
            b1 = int'($urandom_range(127, 0));
            r1 = int'($urandom_range(127, 0));
            k  = int'($urandom_range(35, 2));
            mid_pass($sformatf("rand_mid%0d", i), t, b, r, t1, b1, r1, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scoreboard_formatter.md
# scoreboard_formatter

Downstream of the game controller: takes the raw binary `time_left`, `blue_score`, `red_score` and `game_over` it produces, and turns them into registered BCD digit fields for the scoreboard renderer and seven-segment drivers. Seconds are split into M:SS. Conversion is sequential: a fixed-latency minutes divider followed by one shared serial double-dabble converter. Results are committed atomically with a one-cycle `update` strobe. The block also generates a blink enable for the game-over display.

## Interface
- `BLINK_CYCLES`, default 25000000: half-period of the game-over blink, in clk cycles; legal range ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `time_left` in 8: remaining seconds, 0–255.
- `blue_score` in 7: blue team score, 0–127.
- `red_score` in 7: red team score, 0–127.
- `game_over` in 1: level; high once the match has ended.
- `time_min` out 4: minutes digit, 0–4.
- `time_sec` out 8: seconds as BCD {tens, ones}, 00–59.
- `blue_bcd` out 12: blue score as BCD {hundreds, tens, ones}.
- `red_bcd` out 12: red score as BCD {hundreds, tens, ones}.
- `update` out 1: one-cycle pulse in the cycle new digit values first appear.
- `busy` out 1: high while a conversion pass is in progress.
- `display_on` out 1: blink gate for the renderer.

## Operation
- Reset values:
  - all digit outputs 0;
  - `update`, `busy` = 0; `display_on` = 1;
  - FSM in IDLE; snapshot registers 0; `primed` = 0; blink counter 0.
- FSM states are IDLE → SNAP → MIN → CONV_SEC → CONV_BLUE → CONV_RED → COMMIT → IDLE.
- **IDLE**: go to SNAP when `primed` = 0, or when any of {time_left, blue_score, red_score} differs from the snapshot.
- **SNAP** (1 cycle):
  - capture the three inputs into the snapshot;
  - load rem = time_left and min = 0;
  - set `primed` = 1 and `busy` = 1.
- **MIN** (exactly 4 cycles, independent of value): each cycle, if rem ≥ 60 then rem −= 60 and min += 1. Widths: rem is 8 bit, min is 3 bit; 255 gives 4:15.
- **CONV_x**: pulse `start` to the converter with operand rem, then {0, blue}, then {0, red}. Wait for `done` and latch the 12-bit BCD result into a staging register. Seconds use only the low 8 bits; the hundreds digit is always 0 there.
- **COMMIT** (1 cycle):
  - copy staging and min to the outputs;
  - assert `update`;
  - deassert `busy`.
- The snapshot is frozen from SNAP to COMMIT. Input changes during a pass are ignored until IDLE, then trigger a new pass. The final input value is therefore always displayed.
- Simultaneous changes to several inputs are handled in one pass.
- Blink:
  - `game_over` = 0: counter held at 0, `display_on` = 1.
  - `game_over` = 1: the counter runs 0..BLINK_CYCLES−1 and `display_on` toggles on wrap. It starts at 1 and first goes low BLINK_CYCLES cycles after `game_over` rises.
  - The blink logic is independent of the FSM.
- Reset asserted mid-pass: everything returns to reset values immediately, no `update` is issued, and a fresh pass starts after release because `primed` = 0.

## Timing
- Converter, `start` in cycle t:
  - the operand loads at edge t;
  - 8 shift-add-3 steps run at edges t+1..t+8;
  - `done` and the valid result are high in cycle t+9 for 1 cycle.
- A pass takes 1 SNAP + 4 MIN + 3×(1 start + 9) + 1 COMMIT, so `update` goes high exactly 36 cycles after the SNAP cycle.
- `busy` is high from the cycle after SNAP entry through the cycle before `update`.
- Outputs change only at the edge that raises `update`; they are never partially updated.
- The minimum spacing between successive `update` pulses is 37 cycles, because IDLE takes 1 cycle.

## Structure
- Shared package `scoreboard_pkg`:
  - FSM state enum;
  - `MIN_STEPS` = 4, `SEC_PER_MIN` = 60, `CONV_BITS` = 8;
  - the BCD digit typedef (4 bit).
- Sub-module `bin2bcd_serial`:
  - ports: clk, rst, start, bin[7:0] in; bcd[11:0], done out;
  - internal 20-bit shift register and 4-bit step counter;
  - a `start` while busy is ignored.
- Blink counter lives in the top level as a separate always block.

## Test plan
- Release reset with time_left = 180 and scores 0: one pass → `update` at SNAP+36, time_min = 3, time_sec = 0x00, blue_bcd = red_bcd = 0x000.
- time_left = 255, blue_score = 127, red_score = 99 → time_min = 4, time_sec = 0x15, blue_bcd = 0x127, red_bcd = 0x099.
- Change blue_score 5→6 at cycle SNAP+10: first `update` shows 0x005; a second pass starts in the following IDLE and shows 0x006.
- Assert `rst` at SNAP+20:
  - outputs must be 0 immediately and no `update` is issued;
  - after release, a pass with the current inputs completes at the new SNAP+36.
- BLINK_CYCLES = 4, `game_over` rising at cycle g:
  - `display_on` is 1 for g..g+3, 0 for g+4..g+7, and so on;
  - dropping `game_over` forces it to 1 the next cycle.
- time_left 60 → 59 → 0 stepped between passes: time_min/time_sec read 1/0x00, then 0/0x59, then 0/0x00.
